// File: rtl/hex_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hex_scan_ctrl
// Description : Time-multiplexed scan controller for a multi-digit 7-segment
//               display sharing one hex decoder, with a one-deep load buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int GAP_CYC    = 50
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_valid,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    output logic                    load_ready,
    input  logic                    blank_lz,
    output logic [3:0]              nibble,
    output logic [NUM_DIGITS-1:0]   digit_en_n,
    output logic                    seg_blank,
    output logic                    frame_done
);

    localparam int c_data_w = 4 * NUM_DIGITS;
    localparam int c_idx_w  = $clog2(NUM_DIGITS);
    localparam int c_scan_w = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_gap_w  = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int c_cnt_w  = (c_scan_w > c_gap_w) ? c_scan_w : c_gap_w;

    localparam logic [c_cnt_w-1:0] c_scan_last = c_cnt_w'(SCAN_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_gap_last  = c_cnt_w'(GAP_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_idx_w-1:0] c_idx_last  = c_idx_w'(NUM_DIGITS - 1);
    localparam logic [c_idx_w-1:0] c_idx_one   = c_idx_w'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t                r_state;
    logic [c_idx_w-1:0]    r_idx;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [c_data_w-1:0]   r_disp;
    logic [c_data_w-1:0]   r_pend;
    logic                  r_pend_full;
    logic [3:0]            r_nibble;
    logic [NUM_DIGITS-1:0] r_digit_en_n;
    logic                  r_seg_blank;
    logic                  r_frame_done;

    state_t                w_state_nx;
    logic [c_idx_w-1:0]    w_idx_nx;
    logic [c_cnt_w-1:0]    w_cnt_nx;
    logic [c_data_w-1:0]   w_disp_nx;
    logic                  w_take_pend;
    logic                  w_boundary;
    logic                  w_accept;
    logic [NUM_DIGITS-1:0] w_sup;
    logic                  w_zrun;
    logic [3:0]            w_nibble_nx;
    logic [NUM_DIGITS-1:0] w_digit_en_n_nx;
    logic                  w_seg_blank_nx;

    assign load_ready = rst_n & ~r_pend_full;
    assign w_accept   = load_valid & load_ready;

    // Next-state: scan sequencing and pending-value transfer
    always_comb begin
        w_state_nx  = r_state;
        w_idx_nx    = r_idx;
        w_cnt_nx    = r_cnt;
        w_take_pend = 1'b0;
        w_boundary  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_pend_full) begin
                    w_take_pend = 1'b1;
                    w_idx_nx    = '0;
                    w_cnt_nx    = '0;
                    w_state_nx  = ST_ON;
                end
            end
            ST_ON: begin
                if (r_cnt == c_scan_last) begin
                    w_cnt_nx   = '0;
                    w_state_nx = ST_GAP;
                end else begin
                    w_cnt_nx = r_cnt + c_cnt_one;
                end
            end
            ST_GAP: begin
                if (r_cnt == c_gap_last) begin
                    w_cnt_nx   = '0;
                    w_state_nx = ST_ON;
                    if (r_idx == c_idx_last) begin
                        w_idx_nx    = '0;
                        w_boundary  = 1'b1;
                        w_take_pend = r_pend_full;
                    end else begin
                        w_idx_nx = r_idx + c_idx_one;
                    end
                end else begin
                    w_cnt_nx = r_cnt + c_cnt_one;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
        w_disp_nx = w_take_pend ? r_pend : r_disp;
    end

    // A digit is suppressed when it and every more significant nibble are zero
    always_comb begin
        w_sup  = '0;
        w_zrun = blank_lz;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            w_zrun   = w_zrun & (w_disp_nx[i*4 +: 4] == 4'h0);
            w_sup[i] = w_zrun;
        end
    end

    // Outputs are derived from post-edge state so they register in step
    always_comb begin
        w_nibble_nx     = 4'h0;
        w_digit_en_n_nx = '1;
        w_seg_blank_nx  = 1'b1;
        if (w_state_nx == ST_ON) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_idx_nx == c_idx_w'(i) && !w_sup[i]) begin
                    w_nibble_nx        = w_disp_nx[i*4 +: 4];
                    w_digit_en_n_nx[i] = 1'b0;
                    w_seg_blank_nx     = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_disp       <= '0;
            r_pend       <= '0;
            r_pend_full  <= 1'b0;
            r_nibble     <= 4'h0;
            r_digit_en_n <= '1;
            r_seg_blank  <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_idx        <= w_idx_nx;
            r_cnt        <= w_cnt_nx;
            r_disp       <= w_disp_nx;
            r_nibble     <= w_nibble_nx;
            r_digit_en_n <= w_digit_en_n_nx;
            r_seg_blank  <= w_seg_blank_nx;
            r_frame_done <= w_boundary;
            if (w_accept) begin
                r_pend <= load_data;
            end
            // Accept needs an empty buffer and take needs a full one, so these never collide
            if (w_take_pend) begin
                r_pend_full <= 1'b0;
            end else if (w_accept) begin
                r_pend_full <= 1'b1;
            end
        end
    end

    assign nibble     = r_nibble;
    assign digit_en_n = r_digit_en_n;
    assign seg_blank  = r_seg_blank;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_hex_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hex_scan_ctrl
// Description : Self-checking bench for hex_scan_ctrl against a frame-timing
//               reference model; directed scenarios followed by random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_scan_ctrl;

    localparam int ND    = 4;
    localparam int SCAN  = 4;
    localparam int GAP   = 1;
    localparam int SLOT  = SCAN + GAP;
    localparam int FRAME = ND * SLOT;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load_valid;
    logic [15:0]   load_data;
    logic          load_ready;
    logic          blank_lz;
    logic [3:0]    nibble;
    logic [ND-1:0] digit_en_n;
    logic          seg_blank;
    logic          frame_done;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: display time measured from the first lit cycle
    bit          m_active;
    int          m_t;
    logic [15:0] m_disp;
    logic [15:0] m_pend;
    bit          m_full;
    bit          m_fd;
    bit          m_blz;

    hex_scan_ctrl #(
        .NUM_DIGITS (ND),
        .SCAN_DIV   (SCAN),
        .GAP_CYC    (GAP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .blank_lz   (blank_lz),
        .nibble     (nibble),
        .digit_en_n (digit_en_n),
        .seg_blank  (seg_blank),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit old_full;
        if (!rst_n) begin
            m_active = 0;
            m_t      = 0;
            m_disp   = '0;
            m_pend   = '0;
            m_full   = 0;
            m_fd     = 0;
            m_blz    = 0;
        end else begin
            old_full = m_full;
            m_fd     = 0;
            m_blz    = blank_lz;
            if (!m_active) begin
                if (old_full) begin
                    m_disp   = m_pend;
                    m_full   = 0;
                    m_active = 1;
                    m_t      = 0;
                end
            end else begin
                m_t = m_t + 1;
                if (m_t % FRAME == 0) begin
                    m_fd = 1;
                    if (old_full) begin
                        m_disp = m_pend;
                        m_full = 0;
                    end
                end
            end
            if (load_valid && !old_full) begin
                m_pend = load_data;
                m_full = 1;
            end
        end
    endtask

    task automatic compare_outputs();
        int          pos;
        int          d;
        bit          lit;
        logic [15:0] upper;
        logic [3:0]  exp_en;
        logic [3:0]  exp_nib;
        lit     = 0;
        exp_en  = 4'hF;
        exp_nib = 4'h0;
        if (m_active) begin
            pos   = m_t % FRAME;
            d     = pos / SLOT;
            upper = m_disp >> (4 * d);
            lit   = ((pos % SLOT) < SCAN) && !(m_blz && d > 0 && upper == 16'h0);
            if (lit) begin
                exp_en  = ~(4'b0001 << d);
                exp_nib = upper[3:0];
            end
        end
        check("digit_en_n", digit_en_n, exp_en);
        check("nibble", nibble, exp_nib);
        check("seg_blank", seg_blank, !lit);
        check("frame_done", frame_done, m_fd);
        check("load_ready", load_ready, rst_n && !m_full);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_outputs();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic load_value(input logic [15:0] v);
        logic rdy;
        bit   done;
        done       = 0;
        load_valid = 1'b1;
        load_data  = v;
        for (int k = 0; k < 100 && !done; k++) begin
            rdy = load_ready;
            step();
            if (rdy) done = 1;
        end
        check("load_accept", done, 1);
        load_valid = 1'b0;
    endtask

    function automatic logic [15:0] rand_value();
        int          k;
        logic [31:0] r;
        k = $urandom_range(0, 4);
        r = $urandom;
        if (k == 0) return 16'h0;
        return r[15:0] & 16'((32'h1 << (4 * k)) - 1);
    endfunction

    initial begin
        logic rdy;
        bit   got_fd;
        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        blank_lz   = 1'b0;
        #1;

        run(3);
        rst_n = 1'b1;
        run(10);

        load_value(16'h12A0);
        run(45);

        load_value(16'h0001);
        load_value(16'h0002);
        run(45);

        blank_lz = 1'b1;
        load_value(16'h0050);
        run(45);
        load_value(16'h0000);
        run(45);

        got_fd = 0;
        for (int k = 0; k < 40 && !got_fd; k++) begin
            step();
            if (frame_done) got_fd = 1;
        end
        check("frame_done_wait", got_fd, 1);
        load_value(16'h7777);
        for (int k = 0; k < 40; k++) begin
            if (m_active && ((m_t % FRAME) / SLOT) == 2 && (m_t % SLOT) < SCAN) break;
            step();
        end
        check("pend_full_before_reset", load_ready, 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        run(45);

        for (int c = 0; c < 3000; c++) begin
            rdy = load_ready;
            step();
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
            if (load_valid && rdy) load_valid = 1'b0;
            if (!load_valid && $urandom_range(0, 39) == 0) begin
                load_valid = 1'b1;
                load_data  = rand_value();
            end
            if ($urandom_range(0, 149) == 0) blank_lz = ~blank_lz;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hex_scan_ctrl.md
# hex_scan_ctrl

Time-multiplexed scan controller for a multi-digit 7-segment display that shares one hex-to-7-segment decoder among all digits. It accepts a packed multi-nibble value over a valid/ready load interface and buffers one pending value. Each refresh frame it presents one nibble at a time to the shared decoder while enabling that digit's common line. It sits between the value producer (counter, debug register, etc.) and the decoder/display pins. New values take effect only at frame boundaries.

## Interface
- NUM_DIGITS, 4, number of digits scanned (2..8)
- SCAN_DIV, 50000, clock cycles each digit is lit (>=1)
- GAP_CYC, 50, dead-time cycles with all digits off after each digit (>=1)
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- load_valid  in  1  producer has a value on load_data
- load_data  in  4*NUM_DIGITS  packed nibbles; [3:0] = digit 0 (least significant)
- load_ready  out  1  controller can accept a value
- blank_lz  in  1  1 = suppress leading zeros
- nibble  out  4  nibble to shared decoder switch input
- digit_en_n  out  NUM_DIGITS  active-low one-hot digit common enables
- seg_blank  out  1  1 = downstream forces all segments off
- frame_done  out  1  one-cycle pulse at each frame boundary

## Operation
- Registers: disp (NUM_DIGITS nibbles), pend (same width), pend_full, idx (digit index), cnt (phase counter), state.
- States: IDLE, ON, GAP.
  - IDLE: all outputs blank. If pend_full: disp<=pend, pend_full<=0, idx<=0, cnt<=0, go ON.
  - ON: digit idx lit; cnt counts 0..SCAN_DIV-1; at SCAN_DIV-1 go GAP, cnt<=0.
  - GAP: all digits off; cnt counts 0..GAP_CYC-1; at GAP_CYC-1 go ON, cnt<=0, idx<=idx+1, wrapping NUM_DIGITS-1 -> 0.
- Frame boundary: the GAP->ON transition with idx wrapping to 0. At that edge: frame_done<=1 for one cycle; if pend_full then disp<=pend, pend_full<=0.
- Load: load_ready = rst_n & ~pend_full. Accept when load_valid & load_ready: pend<=load_data, pend_full<=1. One-deep buffer; the producer holds data while ready is low.
- Simultaneous accept and frame boundary: the accept is possible only if pend_full=0. The new value lands in pend and is applied at the next boundary (or the next IDLE cycle).
- Leading-zero suppression: digit i>0 is blank when blank_lz=1 and nibbles i..NUM_DIGITS-1 of disp are all zero. Digit 0 is never suppressed.
- Outputs are registered and reflect state/idx after the same edge.
  - ON and not suppressed: digit_en_n = ~(1<<idx), nibble = disp[idx], seg_blank = 0.
  - ON and suppressed, GAP, or IDLE: digit_en_n = all ones, nibble = 0, seg_blank = 1.
- Reset (any state, any cycle): state=IDLE, idx=0, cnt=0, disp=0, pend=0, pend_full=0. Any pending value is discarded. The display stays blank until a new load.

## Timing
- Reset values: digit_en_n all ones, seg_blank=1, nibble=0, frame_done=0, load_ready=0 while rst_n=0; load_ready=1 the first cycle after release.
- First load after IDLE: accepted at edge E0; IDLE transfer at E1; digit 0 lit in the cycle after E1 (2 edges after acceptance).
- Frame period: exactly NUM_DIGITS*(SCAN_DIV+GAP_CYC) cycles. frame_done is high during the first ON cycle of digit 0, every frame, and never in the first frame after IDLE.
- Per digit: exactly SCAN_DIV lit cycles followed by GAP_CYC dark cycles. Two digit enables are never low together.
- load_ready latency: drops the cycle after acceptance; rises the cycle after the boundary that consumes pend.
- Counter widths are sized with $clog2 of SCAN_DIV and GAP_CYC. No wrap other than those stated.

## Test plan
All scenarios use NUM_DIGITS=4, SCAN_DIV=4, GAP_CYC=1, frame = 20 cycles.
- Hold rst_n=0 for 3 cycles, then release -> during reset digit_en_n=1111, seg_blank=1, load_ready=0, frame_done=0; after release load_ready=1 and the display stays blank with no load.
- Load 16'h12A0 with blank_lz=0 -> the display repeats this cycle sequence every 20 cycles, with frame_done pulsing every 20 cycles:
  - 4 cycles 1110/nibble 0, 1 cycle 1111
  - 4 cycles 1101/nibble A, 1 cycle 1111
  - 4 cycles 1011/nibble 2, 1 cycle 1111
  - 4 cycles 0111/nibble 1, 1 cycle 1111
- While 16'h12A0 is displayed, load 16'h0001 mid-frame and hold load_valid with 16'h0002 -> load_ready=0 until the boundary. The display changes to 0001 exactly at the frame_done cycle. 0002 is accepted the cycle after ready rises and is shown one frame later.
- With blank_lz=1:
  - 16'h0050 -> the digit 2 and 3 slots have digit_en_n=1111 and seg_blank=1; digit 0 shows nibble 0 and digit 1 shows 5.
  - 16'h0000 -> only digit 0 is lit, showing 0.
- Assert rst_n=0 for 1 cycle during the digit 2 ON slot with pend_full=1 -> the next cycle is blank, load_ready=1, the pending value is never displayed, and the display remains blank until a new load.
